// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver FSM states, parity modes,
// baud divider arithmetic, majority vote and parity computation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_STOP2     = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } rx_state_t;

  localparam int PAR_NONE      = 32'sd0;
  localparam int PAR_EVEN      = 32'sd1;
  localparam int PAR_ODD       = 32'sd2;
  localparam int MAX_DATA_BITS = 32'sd9;

  // Clocks per oversample tick.
  function automatic int calc_div(input int in_freq, input int out_freq, input int oversample);
    if ((out_freq < 32'sd1) || (oversample < 32'sd1)) begin
      return 32'sd0;
    end else begin
      return in_freq / (out_freq * oversample);
    end
  endfunction

  // True when the clock divides into an integral, non-zero tick period.
  function automatic bit div_is_valid(input int in_freq, input int out_freq, input int oversample);
    if ((out_freq < 32'sd1) || (oversample < 32'sd1)) begin
      return 1'b0;
    end else begin
      return ((in_freq % (out_freq * oversample)) == 32'sd0) &&
             ((in_freq / (out_freq * oversample)) >= 32'sd1);
    end
  endfunction

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Expected parity bit; unused upper bits must be zero.
  function automatic logic parity_expect(input logic [MAX_DATA_BITS-1:0] word, input int mode);
    if (mode == PAR_ODD) begin
      return ~(^word);
    end else begin
      return ^word;
    end
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clks, phase
// restartable with clear so the first tick lands DIV clks later.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int IN_FREQ    = 64,
  parameter int OUT_FREQ   = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DIV = calc_div(IN_FREQ, OUT_FREQ, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          tick_r;

  // Next divider phase; clear restarts at phase 0.
  always_comb begin
    cnt_nxt_s = {CW{1'b0}};
    if (clear) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
  end

  // Divider phase and registered tick, high while the phase sits at DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= (cnt_nxt_s == CNT_LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_receive_ext.sv
// Configurable UART receiver: 5-9 data bits, none/even/odd parity,
// 1 or 2 stop bits, 16x oversampling with mid-bit 2-of-3 vote,
// false-start rejection and sticky framing/parity/overrun flags.
module uart_receive_ext
  import uart_pkg::*;
#(
  parameter int IN_FREQ    = 64,
  parameter int OUT_FREQ   = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data,
  output logic                 ready,
  input  logic                 reset_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  if (!div_is_valid(IN_FREQ, OUT_FREQ, OVERSAMPLE)) begin : g_bad_div
    $error("uart_receive_ext: IN_FREQ/(OUT_FREQ*OVERSAMPLE) must be an integer >= 1");
  end
  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
      (PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_fmt
    $error("uart_receive_ext: unsupported frame format parameters");
  end

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_LAST   = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] SC_MID_M1 = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_MID    = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SC_MID_P1 = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]     BIT_LAST  = 4'(DATA_BITS - 1);

  logic                 sync1_r;
  logic                 rx_s;
  logic                 tick_s;
  logic                 clear_s;
  logic [SCW-1:0]       sc_r;
  logic [SCW-1:0]       sc_nxt_s;
  logic                 v0_r;
  logic                 v1_r;
  logic                 vote_s;
  logic                 decide_s;
  logic                 complete_s;
  rx_state_t            state_r;
  logic [3:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 perr_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 ready_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 busy_r;

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx_i;
      rx_s    <= sync1_r;
    end
  end

  uart_baud_tick #(
    .IN_FREQ   (IN_FREQ),
    .OUT_FREQ  (OUT_FREQ),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(clear_s),
    .tick (tick_s)
  );

  // Sample position, bit decision strobe, vote and frame completion.
  always_comb begin
    sc_nxt_s   = {SCW{1'b0}};
    clear_s    = 1'b0;
    complete_s = 1'b0;
    if (sc_r == SC_LAST) begin
      sc_nxt_s = {SCW{1'b0}};
    end else begin
      sc_nxt_s = sc_r + SCW'(1);
    end
    if ((state_r == ST_IDLE) && !rx_s) begin
      clear_s = 1'b1;
    end else begin
      clear_s = 1'b0;
    end
    decide_s = tick_s && (sc_nxt_s == SC_MID_P1);
    vote_s   = maj3(v0_r, v1_r, rx_s);
    if (decide_s && (state_r == ST_STOP) && (!vote_s || (STOP_BITS == 1))) begin
      complete_s = 1'b1;
    end else if (decide_s && (state_r == ST_STOP2)) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
  end

  // Receiver FSM with sampling, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      sc_r         <= {SCW{1'b0}};
      v0_r         <= 1'b1;
      v1_r         <= 1'b1;
      bit_cnt_r    <= 4'd0;
      shift_r      <= {DATA_BITS{1'b0}};
      perr_r       <= 1'b0;
      data_r       <= {DATA_BITS{1'b0}};
      ready_r      <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (reset_ready) begin
        ready_r      <= 1'b0;
        parity_err_r <= 1'b0;
        frame_err_r  <= 1'b0;
        overrun_r    <= 1'b0;
      end
      if (tick_s) begin
        sc_r <= sc_nxt_s;
        if (sc_nxt_s == SC_MID_M1) v0_r <= rx_s;
        if (sc_nxt_s == SC_MID)    v1_r <= rx_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) begin
            state_r <= ST_START;
            sc_r    <= {SCW{1'b0}};
            perr_r  <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_START: begin
          if (decide_s) begin
            if (vote_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 4'd0;
            end
          end
        end
        ST_DATA: begin
          if (decide_s) begin
            shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
            if (bit_cnt_r == BIT_LAST) begin
              state_r <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (decide_s) begin
            perr_r  <= (vote_s != parity_expect(MAX_DATA_BITS'(shift_r), PARITY));
            state_r <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (decide_s) begin
            if (!vote_s) begin
              state_r <= ST_WAIT_IDLE;
            end else if (STOP_BITS == 2) begin
              state_r <= ST_STOP2;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        ST_STOP2: begin
          if (decide_s) begin
            if (!vote_s) begin
              state_r <= ST_WAIT_IDLE;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      // Completion overrides a coincident reset_ready pulse.
      if (complete_s) begin
        data_r       <= shift_r;
        ready_r      <= 1'b1;
        parity_err_r <= perr_r;
        frame_err_r  <= ~vote_s;
        overrun_r    <= reset_ready ? 1'b0 : (overrun_r | ready_r);
      end
    end
  end

  assign data       = data_r;
  assign ready      = ready_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule
